// File: rtl/sync_debounce_edge.sv
// Multi-channel input conditioner: reset synchroniser, per-channel N-flop synchroniser,
// debounce counter and registered rise/fall/any-edge event pulses.
module sync_debounce_edge #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned RST_STAGES  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] edge_en_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             any_edge_o,
    output logic             rst_sync_o
);

    localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || RST_STAGES < 2 || RST_STAGES > 4 ||
        DEBOUNCE < 1 || DEBOUNCE > 255) begin : gen_bad_params
        $error("sync_debounce_edge: parameter out of legal range");
    end

    // Reset: asserted asynchronously, released after RST_STAGES clock edges.
    logic [RST_STAGES-1:0] rst_chain_q;
    logic                  rst_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_chain_q <= '0;
        end else begin
            rst_chain_q <= {rst_chain_q[RST_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = rst_chain_q[RST_STAGES-1];

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  synced;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]                  level_q, level_d;
    logic [WIDTH-1:0]                  flip;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;
    logic                              any_q;

    assign synced = sync_q[SYNC_STAGES-1];

    // The counter only runs while the synchronised input disagrees with the level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        flip    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (synced[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    flip[i]    = 1'b1;
                    level_d[i] = synced[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        rise_d = flip & synced & edge_en_i;
        fall_d = flip & ~synced & edge_en_i;
    end

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], data_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= |(rise_q | fall_q);
        end
    end

    assign level_o    = level_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign any_edge_o = any_q;
    assign rst_sync_o = rst_sync;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Scoreboard bench: two instances (defaults, and SYNC_STAGES=3/DEBOUNCE=1) with expected
// output snapshots queued per stimulus step and compared at the cycle they fall due.
module tb_sync_debounce_edge;

    localparam int S_A = 2;
    localparam int D_A = 4;
    localparam int S_B = 3;
    localparam int D_B = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_a, data_b, edge_en;
    logic [7:0] level_a, rise_a, fall_a, level_b, rise_b, fall_b;
    logic       any_a, any_b, rst_sync_a, rst_sync_b;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int       at;
        logic [7:0] lvl;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       any;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int rise_seen_a = 0, fall_seen_a = 0, any_seen_a = 0;
    int rise_seen_b = 0, fall_seen_b = 0, any_seen_b = 0;
    int rise_exp_a = 0, fall_exp_a = 0, any_exp_a = 0;
    int rise_exp_b = 0, fall_exp_b = 0, any_exp_b = 0;

    sync_debounce_edge #(
        .WIDTH(8), .SYNC_STAGES(S_A), .DEBOUNCE(D_A), .RST_STAGES(2)
    ) dut_a (
        .clk(clk), .rst(rst), .data_i(data_a), .edge_en_i(edge_en),
        .level_o(level_a), .rise_o(rise_a), .fall_o(fall_a),
        .any_edge_o(any_a), .rst_sync_o(rst_sync_a)
    );

    sync_debounce_edge #(
        .WIDTH(8), .SYNC_STAGES(S_B), .DEBOUNCE(D_B), .RST_STAGES(2)
    ) dut_b (
        .clk(clk), .rst(rst), .data_i(data_b), .edge_en_i(edge_en),
        .level_o(level_b), .rise_o(rise_b), .fall_o(fall_b),
        .any_edge_o(any_b), .rst_sync_o(rst_sync_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Queue snapshots around a level change due after edge d: quiet before, pulse at d,
    // any_edge one cycle later, everything quiet again after that.
    task automatic push(input bit to_b, input int d, input logic [7:0] lb, input logic [7:0] la,
                        input logic [7:0] r, input logic [7:0] f);
        exp_t e[4];
        e[0] = '{at: d - 1, lvl: lb, rise: 8'h00, fall: 8'h00, any: 1'b0};
        e[1] = '{at: d,     lvl: la, rise: r,     fall: f,     any: 1'b0};
        e[2] = '{at: d + 1, lvl: la, rise: 8'h00, fall: 8'h00, any: |(r | f)};
        e[3] = '{at: d + 2, lvl: la, rise: 8'h00, fall: 8'h00, any: 1'b0};
        for (int i = 0; i < 4; i++) begin
            if (to_b) q_b.push_back(e[i]);
            else      q_a.push_back(e[i]);
        end
        if (to_b) begin
            rise_exp_b += $countones(r);
            fall_exp_b += $countones(f);
            any_exp_b  += (|(r | f)) ? 1 : 0;
        end else begin
            rise_exp_a += $countones(r);
            fall_exp_a += $countones(f);
            any_exp_a  += (|(r | f)) ? 1 : 0;
        end
    endtask

    // Drive dut_a now; the input is first sampled on the next edge.
    task automatic drive_a(input logic [7:0] v, input logic [7:0] lb, input logic [7:0] la,
                           input logic [7:0] r, input logic [7:0] f);
        data_a = v;
        push(1'b0, cyc + S_A + D_A, lb, la, r, f);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("drain", q_a.size() + q_b.size(), 0);
        q_a.delete();
        q_b.delete();
        repeat (2) begin @(negedge clk); #1; end
        check("rise_count_a", rise_seen_a, rise_exp_a);
        check("fall_count_a", fall_seen_a, fall_exp_a);
        check("any_count_a",  any_seen_a,  any_exp_a);
        check("rise_count_b", rise_seen_b, rise_exp_b);
        check("fall_count_b", fall_seen_b, fall_exp_b);
        check("any_count_b",  any_seen_b,  any_exp_b);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        rise_seen_a += $countones(rise_a);
        fall_seen_a += $countones(fall_a);
        any_seen_a  += any_a ? 1 : 0;
        rise_seen_b += $countones(rise_b);
        fall_seen_b += $countones(fall_b);
        any_seen_b  += any_b ? 1 : 0;
        while (q_a.size() > 0 && q_a[0].at <= cyc) begin
            e = q_a.pop_front();
            check("a_when",  cyc, e.at);
            check("a_level", level_a, e.lvl);
            check("a_rise",  rise_a, e.rise);
            check("a_fall",  fall_a, e.fall);
            check("a_any",   any_a, e.any);
        end
        while (q_b.size() > 0 && q_b[0].at <= cyc) begin
            e = q_b.pop_front();
            check("b_when",  cyc, e.at);
            check("b_level", level_b, e.lvl);
            check("b_rise",  rise_b, e.rise);
            check("b_fall",  fall_b, e.fall);
            check("b_any",   any_b, e.any);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int rel;
        int c;
        rst     = 1'b0;
        data_a  = 8'h00;
        data_b  = 8'h00;
        edge_en = 8'hFF;

        // Reset release
        repeat (3) @(negedge clk);
        #1;
        check("rst_sync_a_low", rst_sync_a, 0);
        check("rst_sync_b_low", rst_sync_b, 0);
        check("rst_level_a", level_a, 0);
        check("rst_level_b", level_b, 0);
        check("rst_pulses_a", {rise_a, fall_a, 7'b0, any_a}, 0);
        rst = 1'b1;
        rel = cyc;
        @(negedge clk); #1;
        check("rst_sync_edge1", rst_sync_a, 0);
        check("rst_sync_edge1_cyc", cyc, rel + 1);
        @(negedge clk); #1;
        check("rst_sync_edge2_a", rst_sync_a, 1);
        check("rst_sync_edge2_b", rst_sync_b, 1);
        repeat (4) begin @(negedge clk); #1; end
        check("idle_level_a", level_a, 0);
        check("idle_any_a", any_a, 0);

        // Clean step up and back down on channel 0
        drive_a(8'h01, 8'h00, 8'h01, 8'h01, 8'h00);
        wait_idle();
        drive_a(8'h00, 8'h01, 8'h00, 8'h00, 8'h01);
        wait_idle();

        // Glitch of DEBOUNCE-1 cycles is rejected
        data_a = 8'h08;
        repeat (3) @(negedge clk);
        #1;
        data_a = 8'h00;
        repeat (10) begin @(negedge clk); #1; end
        check("glitch3_level", level_a, 8'h00);
        wait_idle();

        // Glitch of exactly DEBOUNCE cycles passes, then falls back
        drive_a(8'h08, 8'h00, 8'h08, 8'h08, 8'h00);
        repeat (4) @(negedge clk);
        #1;
        drive_a(8'h00, 8'h08, 8'h00, 8'h00, 8'h08);
        wait_idle();

        // Enable masking on channel 0
        edge_en = 8'hFE;
        drive_a(8'h03, 8'h00, 8'h03, 8'h02, 8'h00);
        wait_idle();
        drive_a(8'h00, 8'h03, 8'h00, 8'h00, 8'h02);
        wait_idle();
        edge_en = 8'hFF;

        // All channels at once, then partial fall
        drive_a(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00);
        wait_idle();
        drive_a(8'h0F, 8'hFF, 8'h0F, 8'h00, 8'hF0);
        wait_idle();
        drive_a(8'h00, 8'h0F, 8'h00, 8'h00, 8'h0F);
        wait_idle();

        // Reset mid-debounce: channel 0 already high, channel 1 counting
        drive_a(8'h01, 8'h00, 8'h01, 8'h01, 8'h00);
        wait_idle();
        data_a = 8'h03;
        c = cyc;
        repeat (2) @(negedge clk);
        #1;
        data_b = 8'h02;
        repeat (2) @(negedge clk);
        #1;
        check("pre_rst_cyc", cyc, c + 4);
        check("pre_rst_level_a", level_a, 8'h01);
        check("pre_rst_level_b", level_b, 8'h00);
        rst = 1'b0;
        #1;
        check("async_rst_level_a", level_a, 8'h00);
        check("async_rst_sync_a", rst_sync_a, 0);
        check("async_rst_pulses_a", {rise_a, fall_a, 7'b0, any_a}, 0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        rel = cyc;
        // First sampling edge is the one after rst_sync rises (edge rel+2).
        push(1'b0, rel + 3 + S_A + D_A - 1, 8'h00, 8'h03, 8'h03, 8'h00);
        push(1'b1, rel + 3 + S_B + D_B - 1, 8'h00, 8'h02, 8'h02, 8'h00);
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("rerelease_rst_sync", rst_sync_a, 1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_debounce_edge.md
Name: sync_debounce_edge

Overview:
- Multi-channel input conditioner for asynchronous external signals.
- Generalises the single-bit register/edge path with:
  - an internal reset synchroniser;
  - a parametrised N-stage per-channel synchroniser;
  - a per-channel debounce counter;
  - registered rise, fall and any-edge pulses with a per-channel enable.
- Sits directly behind the chip-level pins.
- Feeds clean levels and single-cycle event pulses to control logic and the interrupt aggregator.

Parameters:
- WIDTH, 8: number of independent input channels.
- SYNC_STAGES, 2: synchroniser flops per channel. Legal range 2..4.
- DEBOUNCE, 4: consecutive cycles a synchronised value must differ from the current level before the level flips. Legal range 1..255.
- RST_STAGES, 2: reset-deassertion synchroniser depth. Legal range 2..4.

Ports:
- clk  in  1  single system clock; all flops rise-edge.
- rst  in  1  asynchronous, active-low reset.
- data_i  in  WIDTH  raw asynchronous channel inputs.
- edge_en_i  in  WIDTH  per-channel enable for rise_o/fall_o/any_edge_o; synchronous, no sync stage.
- level_o  out  WIDTH  debounced level per channel.
- rise_o  out  WIDTH  1-cycle pulse, level 0->1, gated by edge_en_i.
- fall_o  out  WIDTH  1-cycle pulse, level 1->0, gated by edge_en_i.
- any_edge_o  out  1  OR of (rise_o | fall_o), registered one further cycle.
- rst_sync_o  out  1  internal synchronised active-low reset, exported.

Behaviour:

Reset synchroniser:
- RST_STAGES-bit shift chain.
- rst low: whole chain cleared to 0 immediately (asynchronous).
- rst high: 1 shifts in per clk edge. rst_sync_o goes high on the RST_STAGES-th rising edge after rst deasserts.
- All other flops reset asynchronously by rst_sync_o low. Reset is asserted asynchronously and released synchronously.

Reset values, all taken while rst_sync_o = 0:
- Sync flops, level_o, rise_o, fall_o, any_edge_o: 0.
- Debounce counters: 0.
- rst_sync_o: 0.

Synchroniser:
- Per channel, a SYNC_STAGES shift register; s[i] is the last stage.
- No logic between stages.

Debounce, per channel, counter width clog2(DEBOUNCE):
- s[i] == level_o[i]: counter cleared to 0 on that edge.
- s[i] != level_o[i] and cnt < DEBOUNCE-1: cnt increments.
- s[i] != level_o[i] and cnt == DEBOUNCE-1: level_o[i] <= s[i], cnt <= 0.
- DEBOUNCE = 1: level_o follows s with one cycle delay; counter logic is degenerate but legal.
- Glitch shorter than DEBOUNCE cycles at s: level_o unchanged, counter returns to 0.

Latency:
- A step on data_i, set up before edge k, appears on level_o after edge k+SYNC_STAGES+DEBOUNCE-1.
- With defaults, that is 5 edges after the first sampling edge.

Edge pulses:
- Registered in the same edge as the level update.
- rise_o[i] is high for exactly the first cycle level_o[i] is 1; fall_o[i] likewise for 0. Never both high on one channel.
- edge_en_i[i] is sampled on the same edge as the level update. If low, the pulse is suppressed (not deferred), and level_o still updates.
- any_edge_o = registered |(rise_o|fall_o), so it lags rise_o/fall_o by 1 cycle.
- Simultaneous edges on several channels produce one any_edge_o cycle per pulse-cycle, not per channel.

Reset mid-operation:
- rst low at any time: all outputs go to 0 asynchronously, with no pulse generated.
- After release, a channel whose input is held at 1 debounces up normally and produces a rise_o pulse (if enabled).

No other state; no configuration registers.

Test Plan:
1. Reset release, defaults: rst low 3 cycles, then high -> rst_sync_o rises on the 2nd edge after release. All outputs 0 until then and 0 after, with data_i = 0.
2. Clean step: data_i[0] 0->1 held, edge_en_i = 8'hFF -> level_o[0] = 1 exactly SYNC_STAGES+DEBOUNCE-1 = 5 edges after first sample. rise_o = 8'h01 for 1 cycle. any_edge_o = 1 one cycle later. Then reverse the step -> fall_o = 8'h01 with the same timing.
3. Glitch rejection: data_i[3] pulses high 3 cycles (DEBOUNCE = 4) -> level_o[3] stays 0, no rise_o/fall_o. A 4-cycle pulse -> level_o[3] goes 1 then returns 0 later, producing one rise and one fall pulse.
4. Enable masking: edge_en_i = 8'hFE, data_i = 8'h03 step -> level_o = 8'h03, rise_o = 8'h02 only. any_edge_o pulses once.
5. Multi-channel simultaneous: data_i 8'h00 -> 8'hFF -> rise_o = 8'hFF in one cycle, any_edge_o single 1-cycle pulse. Then 8'hFF -> 8'h0F -> fall_o = 8'hF0.
6. Reset mid-debounce: data_i[1] high, rst asserted at cnt = 2 -> all outputs 0 immediately. After release with data_i[1] still high -> level_o[1] = 1 after rst_sync_o high + 5 edges, with one rise_o pulse. Repeat with DEBOUNCE = 1, SYNC_STAGES = 3: latency 3 edges.
